// File: rtl/mac_pkg.sv
// Shared sizing, FSM state encoding and byte-lane slicing for the MAC array feeder.
package mac_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DW    = 8;
    localparam int VW    = COLS * DW;
    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADW  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    // Column 0 occupies the most significant byte of a row/vector.
    function automatic logic [DW-1:0] lane(input logic [VW-1:0] v, input int j);
        return v[VW-1-DW*j -: DW];
    endfunction

endpackage

// File: rtl/mac_skew_line.sv
// Fixed-depth delay line carrying one byte plus its valid flag, cleared synchronously.
module mac_skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o
);

    logic [DW-1:0] data_q  [DEPTH];
    logic          valid_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/mac_feeder.sv
// Loads a 4x4 weight tile and streams diagonally skewed activation vectors into a systolic MAC array.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting; weight rows take priority, activations need wloaded
// ST_LOADW  | accepting weight rows 1..3 of a tile
// ST_STREAM | accepting activation vectors until one with last set
// ST_DRAIN  | no input; wait for skew plus array flush, then pulse done
module mac_feeder
    import mac_pkg::*;
#(
    parameter int DRAIN_CYCLES = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             w_valid_i,
    output logic             w_ready_o,
    input  logic [VW-1:0]    w_data_i,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [VW-1:0]    a_data_i,
    input  logic             a_last_i,
    output logic             w_load_o,
    output logic [ROW_W-1:0] wrow_o,
    output logic [VW-1:0]    wdata_o,
    output logic [VW-1:0]    idata_o,
    output logic [COLS-1:0]  icol_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int                  DRAIN_W    = $clog2(DRAIN_CYCLES + 3);
    localparam logic [DRAIN_W-1:0]  DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES + 2);
    localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(ROWS - 1);

    state_e             state_q;
    logic [ROW_W-1:0]   row_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               wloaded_q;
    logic               w_load_q;
    logic [ROW_W-1:0]   wrow_q;
    logic [VW-1:0]      wdata_q;
    logic               done_q;

    logic               w_fire;
    logic               a_fire;
    logic [DW-1:0]      col_data  [COLS];
    logic               col_valid [COLS];

    always_comb begin
        w_ready_o = 1'b0;
        a_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_ready_o = 1'b1;
                a_ready_o = wloaded_q & ~w_valid_i;
            end
            ST_LOADW:  w_ready_o = 1'b1;
            ST_STREAM: a_ready_o = 1'b1;
            default: ;
        endcase
    end

    assign w_fire = w_valid_i & w_ready_o;
    assign a_fire = a_valid_i & a_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            drain_q   <= '0;
            wloaded_q <= 1'b0;
            w_load_q  <= 1'b0;
            wrow_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            w_load_q <= w_fire;
            wrow_q   <= w_fire ? row_q : '0;
            wdata_q  <= w_fire ? w_data_i : '0;
            done_q   <= 1'b0;
            if (w_fire) begin
                row_q <= row_q + ROW_W'(1);
                if (row_q == LAST_ROW) wloaded_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_fire) begin
                        state_q <= ST_LOADW;
                    end else if (a_fire) begin
                        if (a_last_i) begin
                            state_q <= ST_DRAIN;
                            drain_q <= DRAIN_LOAD;
                        end else begin
                            state_q <= ST_STREAM;
                        end
                    end
                end
                ST_LOADW: begin
                    if (w_fire && row_q == LAST_ROW) state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (a_fire && a_last_i) begin
                        state_q <= ST_DRAIN;
                        drain_q <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // Terminal count lands so done coincides with the return to idle.
                    if (drain_q == '0) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
        logic [DW-1:0] col_in;
        assign col_in = a_fire ? lane(a_data_i, j) : '0;

        mac_skew_line #(
            .DEPTH (j + 1),
            .DW    (DW)
        ) u_line (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .data_i  (col_in),
            .valid_i (a_fire),
            .data_o  (col_data[j]),
            .valid_o (col_valid[j])
        );
    end

    always_comb begin
        idata_o      = '0;
        icol_valid_o = '0;
        for (int j = 0; j < COLS; j++) begin
            idata_o[VW-1-DW*j -: DW] = col_data[j];
            icol_valid_o[j]          = col_valid[j];
        end
    end

    assign w_load_o = w_load_q;
    assign wrow_o   = wrow_q;
    assign wdata_o  = wdata_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: directed scenarios with literal expectations plus randomized traffic against a cycle-indexed reference model.
module tb_mac_feeder;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [31:0] w_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [31:0] a_data = '0;
    logic        a_last = 1'b0;
    logic        w_load;
    logic [1:0]  wrow;
    logic [31:0] wdata;
    logic [31:0] idata;
    logic [3:0]  icol_valid;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    mac_feeder #(.DRAIN_CYCLES(D)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .w_valid_i    (w_valid),
        .w_ready_o    (w_ready),
        .w_data_i     (w_data),
        .a_valid_i    (a_valid),
        .a_ready_o    (a_ready),
        .a_data_i     (a_data),
        .a_last_i     (a_last),
        .w_load_o     (w_load),
        .wrow_o       (wrow),
        .wdata_o      (wdata),
        .idata_o      (idata),
        .icol_valid_o (icol_valid),
        .busy_o       (busy),
        .done_o       (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: phase 0 idle, 1 loading, 2 streaming, 3 draining.
    int         phase    = 0;
    bit         loaded   = 0;
    int         rows     = 0;
    int         done_cyc = -1;
    bit         mvalid   = 0;
    logic [1:0]  m_wrow  [int];
    logic [31:0] m_wdata [int];
    logic [7:0]  m_slot  [int];

    logic        obs_wload, obs_busy, obs_done, obs_wr, obs_ar;
    logic [1:0]  obs_wrow;
    logic [31:0] obs_wdata, obs_idata;
    logic [3:0]  obs_icol;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic wv, input logic [31:0] wd,
                        input logic av, input logic [31:0] ad, input logic al);
        logic        e_wl, ewr, ear, wf, af;
        logic [1:0]  e_wrow;
        logic [31:0] e_wdata, e_id;
        logic [3:0]  e_iv;
        @(negedge clk);
        if (phase == 3 && cyc == done_cyc) phase = 0;
        obs_wload = w_load; obs_wrow = wrow; obs_wdata = wdata;
        obs_idata = idata;  obs_icol = icol_valid;
        obs_busy  = busy;   obs_done = done;
        if (mvalid) begin
            e_wl    = m_wdata.exists(cyc);
            e_wrow  = e_wl ? m_wrow[cyc] : 2'd0;
            e_wdata = e_wl ? m_wdata[cyc] : 32'd0;
            e_id = '0;
            e_iv = '0;
            for (int j = 0; j < 4; j++) begin
                if (m_slot.exists(cyc*4 + j)) begin
                    e_id[31-8*j -: 8] = m_slot[cyc*4 + j];
                    e_iv[j] = 1'b1;
                    m_slot.delete(cyc*4 + j);
                end
            end
            check("w_load", w_load, e_wl);
            check("wrow", wrow, e_wrow);
            check("wdata", wdata, e_wdata);
            check("idata", idata, e_id);
            check("icol_valid", icol_valid, e_iv);
            check("busy", busy, phase != 0);
            check("done", done, cyc == done_cyc);
            if (e_wl) begin
                m_wrow.delete(cyc);
                m_wdata.delete(cyc);
            end
        end
        rst = r; w_valid = wv; w_data = wd; a_valid = av; a_data = ad; a_last = al;
        #1;
        ewr = 1'b0;
        ear = 1'b0;
        case (phase)
            0: begin ewr = 1'b1; ear = loaded & ~wv; end
            1: ewr = 1'b1;
            2: ear = 1'b1;
            default: ;
        endcase
        obs_wr = w_ready;
        obs_ar = a_ready;
        if (mvalid) begin
            check("w_ready", w_ready, ewr);
            check("a_ready", a_ready, ear);
        end
        wf = !r && wv && ewr;
        af = !r && av && ear;
        if (r) begin
            phase = 0; loaded = 0; rows = 0; done_cyc = -1; mvalid = 1;
            m_wrow.delete(); m_wdata.delete(); m_slot.delete();
        end else begin
            if (wf) begin
                m_wrow[cyc+1]  = 2'(rows % 4);
                m_wdata[cyc+1] = wd;
                rows++;
                if (phase == 0) phase = 1;
                if (rows % 4 == 0) begin
                    loaded = 1;
                    phase  = 2;
                end
            end
            if (af) begin
                for (int j = 0; j < 4; j++) m_slot[(cyc+1+j)*4 + j] = ad[31-8*j -: 8];
                if (al) begin
                    phase    = 3;
                    done_cyc = cyc + 4 + D;
                end else begin
                    phase = 2;
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    logic [31:0] wrows [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    logic [31:0] exp_id4 [4] = '{32'h11000000, 32'h00220000, 32'h00003300, 32'h00000044};
    int tv;

    initial begin
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        // Activations offered with no weights must not be taken.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
            check("lit_idle_wready", obs_wr, 1'b1);
            check("lit_idle_aready", obs_ar, 1'b0);
            check("lit_idle_icol", obs_icol, 4'b0000);
            check("lit_idle_busy", obs_busy, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, wrows[i], 1'b0, 32'd0, 1'b0);
            if (i > 0) begin
                check("lit_wload", obs_wload, 1'b1);
                check("lit_wrow", obs_wrow, 32'(i - 1));
                check("lit_wdata", obs_wdata, wrows[i-1]);
            end
        end
        idle();
        check("lit_wload3", obs_wload, 1'b1);
        check("lit_wrow3", obs_wrow, 32'd3);
        check("lit_wdata3", obs_wdata, wrows[3]);
        check("lit_stream_busy", obs_busy, 1'b1);

        tv = cyc;
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h11223344, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            idle();
            if (k <= 4) begin
                check("lit_skew_icol", obs_icol, 32'(1 << (k - 1)));
                check("lit_skew_idata", obs_idata, exp_id4[k-1]);
            end
            check("lit_done", obs_done, k == 12);
            check("lit_busy", obs_busy, k < 12);
        end

        tv = cyc;
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b0, 32'd0, 1'b1, {4{8'(i)}}, i == 4);
        idle();
        check("lit_diag_icol", obs_icol, 4'b1111);
        check("lit_diag_idata", obs_idata, 32'h04030201);
        for (int k = 0; k < 14; k++) idle();

        step(1'b0, 1'b0, 32'd0, 1'b1, 32'hA1A2A3A4, 1'b0);
        idle();
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'hB1B2B3B4, 1'b1);
        check("lit_bubble_icol", obs_icol, 4'b0010);
        check("lit_bubble_idata", obs_idata, 32'h00A20000);
        for (int k = 0; k < 3; k++) idle();
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle();
        check("lit_rst_icol", obs_icol, 4'b0000);
        check("lit_rst_idata", obs_idata, 32'd0);
        check("lit_rst_busy", obs_busy, 1'b0);
        check("lit_rst_wready", obs_wr, 1'b1);
        for (int k = 0; k < 16; k++) begin
            idle();
            check("lit_rst_nodone", obs_done, 1'b0);
        end

        for (int k = 0; k < 4000; k++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 5) == 0, $urandom,
                 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 3) == 0);
        end
        for (int k = 0; k < 20; k++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
